// File: rtl/bus_interface_unit.sv
// -----------------------------------------------------------------------------
// bus_interface_unit
//
// Bridges a single-request core interface to an external 8-bit memory bus
// that has a 16-bit address and a wait-state input. One access runs at a
// time. A memory that holds rdy low for TIMEOUT consecutive samples ends the
// access with an error response.
//
// Parameters
//   TIMEOUT   0..255  consecutive rdy-low samples that abort an access
//                     (0 disables the timeout)
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   core requests an access
//   req_ready  out  high in IDLE, when a request can be accepted
//   req_we     in   1 = write, 0 = read
//   req_addr   in   [15:0] access address
//   req_wdata  in   [7:0]  write data
//   rsp_valid  out  one-cycle completion pulse
//   rsp_rdata  out  [7:0]  captured read data (8'hFF after a timeout)
//   rsp_err    out  access ended by timeout, valid with rsp_valid
//   addr_out   out  [15:0] external address bus
//   data_out   out  [7:0]  external write data
//   data_oe    out  external data bus drive enable
//   rwb        out  1 = read cycle, 0 = write cycle
//   rdy        in   memory ready, low inserts a wait state
//   data_in    in   [7:0]  external read data
//   busy       out  high while an access is in progress
// -----------------------------------------------------------------------------
module bus_interface_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        rwb,
  input  logic        rdy,
  input  logic [7:0]  data_in,
  output logic        busy
);

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Saturating increment: the wait counter never wraps back to zero.
  logic [7:0]  wait_inc;
  assign wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      wait_cnt_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        // rdy and data_in are don't-care here.
        if (req_valid) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          we_d       = req_we;
          wait_cnt_d = 8'h00;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // Request inputs are ignored; the captured copies drive the bus.
        if (rdy) begin
          // Success wins even if the low-sample count already reached the limit.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (!we_q) begin
            rsp_rdata_d = data_in;
          end
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_inc;
          if ((TimeoutLim != 8'h00) && (wait_inc == TimeoutLim)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 8'hFF;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == ACCESS);
  assign addr_out  = addr_q;
  assign data_out  = wdata_q;
  assign data_oe   = (state_q == ACCESS) & we_q;
  assign rwb       = (state_q == ACCESS) ? ~we_q : 1'b1;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bus_interface_unit.sv
// -----------------------------------------------------------------------------
// tb_bus_interface_unit
//
// Directed bench for bus_interface_unit with TIMEOUT=4. Inputs change 1 time
// unit after a rising edge and outputs are checked at that same point, well
// away from the next active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_interface_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] addr_out;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        rwb;
  logic        rdy;
  logic [7:0]  data_in;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_interface_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .rwb       (rwb),
    .rdy       (rdy),
    .data_in   (data_in),
    .busy      (busy)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control bundle order everywhere: {req_ready, busy, rwb, data_oe, rsp_valid}
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0;
    req_wdata = 8'h0; rdy = 1'b1; data_in = 8'h00;
    #1;
    vectors++;
    if ({req_ready, busy, rwb, data_oe, rsp_valid} !== 5'b10100) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected %b", {req_ready, busy, rwb, data_oe, rsp_valid}, 5'b10100);
    end
    vectors++;
    if ({addr_out, data_out, rsp_rdata, rsp_err} !== {16'h0000, 8'h00, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h dout=%h rdata=%h err=%b expected 0000/00/00/0",
               addr_out, data_out, rsp_rdata, rsp_err);
    end
    // Request offered during reset must not be taken.
    req_valid = 1'b1; req_addr = 16'h5555;
    tick();
    vectors++;
    if ({busy, addr_out} !== {1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_hold: got busy=%b addr=%h expected busy=0 addr=0000", busy, addr_out);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_zero_wait_read();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hFFFC; rdy = 1'b1; data_in = 8'hA9;
    tick();                       // first edge after reset release accepts
    req_valid = 1'b0; req_addr = 16'h0000;
    vectors++;
    if ({req_ready, busy, rwb, data_oe, rsp_valid, addr_out} !== {5'b01100, 16'hFFFC}) begin
      miscompares++;
      $display("FAIL zw_access: got ctrl=%b addr=%h expected ctrl=01100 addr=fffc",
               {req_ready, busy, rwb, data_oe, rsp_valid}, addr_out);
    end
    tick();
    vectors++;
    if ({req_ready, busy, rsp_valid, rsp_rdata, rsp_err} !== {3'b101, 8'hA9, 1'b0}) begin
      miscompares++;
      $display("FAIL zw_rsp: got rdy/busy/v=%b rdata=%h err=%b expected 101 a9 0",
               {req_ready, busy, rsp_valid}, rsp_rdata, rsp_err);
    end
    data_in = 8'h00;
    tick();
    vectors++;
    if ({rsp_valid, rsp_rdata} !== {1'b0, 8'hA9}) begin
      miscompares++;
      $display("FAIL zw_pulse: got v=%b rdata=%h expected v=0 rdata=a9", rsp_valid, rsp_rdata);
    end
    $display("zero_wait_read: addr=fffc rdata=%h err=%b", rsp_rdata, rsp_err);
  endtask

  task automatic test_wait_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h01FD; req_wdata = 8'h34;
    rdy = 1'b0; data_in = 8'h5A;
    tick();
    req_valid = 1'b0; req_addr = 16'hAAAA; req_wdata = 8'hEE; req_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({busy, rwb, data_oe, rsp_valid, addr_out, data_out} !== {4'b1010, 16'h01FD, 8'h34}) begin
        miscompares++;
        $display("FAIL ww_cycle%0d: got ctrl=%b addr=%h dout=%h expected 1010 01fd 34",
                 i, {busy, rwb, data_oe, rsp_valid}, addr_out, data_out);
      end
      rdy = (i == 3);             // three low samples, then ready
      tick();
    end
    vectors++;
    if ({busy, rwb, data_oe, rsp_valid, rsp_err, rsp_rdata} !== {5'b01010, 8'hA9}) begin
      miscompares++;
      $display("FAIL ww_rsp: got ctrl=%b err=%b rdata=%h expected 0101 0 a9",
               {busy, rwb, data_oe, rsp_valid}, rsp_err, rsp_rdata);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ww_single: got rsp_valid=%b expected 0", rsp_valid);
    end
    $display("wait_write: addr=01fd wdata=34 err=%b rdata=%h", rsp_err, rsp_rdata);
  endtask

  task automatic test_timeout();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234; rdy = 1'b0; data_in = 8'h77;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({busy, rsp_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL to_wait%0d: got busy=%b v=%b expected busy=1 v=0", i, busy, rsp_valid);
      end
      tick();
    end
    vectors++;
    if ({busy, rwb, data_oe, rsp_valid, rsp_err, rsp_rdata} !== {5'b01011, 8'hFF}) begin
      miscompares++;
      $display("FAIL to_rsp: got ctrl=%b err=%b rdata=%h expected 0101 1 ff",
               {busy, rwb, data_oe, rsp_valid}, rsp_err, rsp_rdata);
    end
    rdy = 1'b1;
    tick();
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 8'hFF}) begin
      miscompares++;
      $display("FAIL to_hold: got v=%b err=%b rdata=%h expected 0 1 ff", rsp_valid, rsp_err, rsp_rdata);
    end
    $display("timeout: addr=1234 err=%b rdata=%h", rsp_err, rsp_rdata);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_data;
    req_valid = 1'b1; req_we = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr = 16'h0200 + 16'(k);
      tick();                     // accept
      exp_data = 8'hC0 + 8'(k);
      data_in = exp_data;
      req_addr = 16'h0200 + 16'(k + 1);  // next request, ignored during ACCESS
      if (k == 2) req_valid = 1'b0;
      vectors++;
      if ({busy, rsp_valid, addr_out} !== {2'b10, 16'h0200 + 16'(k)}) begin
        miscompares++;
        $display("FAIL b2b_acc%0d: got busy=%b v=%b addr=%h expected 1 0 %h",
                 k, busy, rsp_valid, addr_out, 16'h0200 + 16'(k));
      end
      tick();                     // complete
      vectors++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {3'b110, exp_data}) begin
        miscompares++;
        $display("FAIL b2b_rsp%0d: got rdy=%b v=%b err=%b rdata=%h expected 1 1 0 %h",
                 k, req_ready, rsp_valid, rsp_err, rsp_rdata, exp_data);
      end
      $display("back_to_back: addr=%h rdata=%h", 16'h0200 + 16'(k), rsp_rdata);
    end
    tick();
    vectors++;
    if ({busy, rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_end: got busy=%b v=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0300; req_wdata = 8'h77; rdy = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();                       // one stalled sample
    vectors++;
    if ({busy, rwb, data_oe} !== 3'b101) begin
      miscompares++;
      $display("FAIL rm_stall: got busy/rwb/oe=%b expected 101", {busy, rwb, data_oe});
    end
    #2;
    rst_n = 1'b0;
    #1;                           // no clock edge yet: reset must act at once
    vectors++;
    if ({req_ready, busy, rwb, data_oe, rsp_valid, addr_out, data_out, rsp_rdata, rsp_err}
        !== {5'b10100, 16'h0000, 8'h00, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL rm_async: got ctrl=%b addr=%h dout=%h rdata=%h err=%b expected 10100 0000 00 00 0",
               {req_ready, busy, rwb, data_oe, rsp_valid}, addr_out, data_out, rsp_rdata, rsp_err);
    end
    rdy = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL rm_norsp: got busy=%b v=%b expected 0 0", busy, rsp_valid);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_norsp_after: got v=%b expected 0", rsp_valid);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0400; data_in = 8'h3C;
    tick();
    req_valid = 1'b0;
    tick();
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h3C}) begin
      miscompares++;
      $display("FAIL rm_next: got v=%b err=%b rdata=%h expected 1 0 3c", rsp_valid, rsp_err, rsp_rdata);
    end
    $display("reset_mid_access: next read rdata=%h", rsp_rdata);
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
